// File: rtl/gtech_mux2_arb_if.sv
// Handshake bundle for the two-requester round-robin mux arbiter.
// slave = arbiter side, master = producer/consumer side.
interface gtech_mux2_arb_if #(parameter int WIDTH = 8);
    logic             A_VALID;
    logic [WIDTH-1:0] A_DATA;
    logic             A_LAST;
    logic             A_READY;
    logic             B_VALID;
    logic [WIDTH-1:0] B_DATA;
    logic             B_LAST;
    logic             B_READY;
    logic             Z_VALID;
    logic [WIDTH-1:0] Z_DATA;
    logic             Z_LAST;
    logic             Z_READY;
    logic             S;

    modport slave (
        input  A_VALID, A_DATA, A_LAST, B_VALID, B_DATA, B_LAST, Z_READY,
        output A_READY, B_READY, Z_VALID, Z_DATA, Z_LAST, S
    );

    modport master (
        output A_VALID, A_DATA, A_LAST, B_VALID, B_DATA, B_LAST, Z_READY,
        input  A_READY, B_READY, Z_VALID, Z_DATA, Z_LAST, S
    );
endinterface

// File: rtl/gtech_mux2_arb.sv
// Round-robin arbiter for a shared 2:1 mux feeding a 1-entry registered output slot.
// Define GTECH_MUX2_ARB_LOCK_EN to hold the grant on one requester until its LAST beat.
module gtech_mux2_arb #(
    parameter int WIDTH = 8
) (
    input logic              CP,
    input logic              CD,
    gtech_mux2_arb_if.slave  bus
);
    logic             z_valid_q, z_valid_d;
    logic [WIDTH-1:0] z_data_q, z_data_d;
    logic             z_last_q, z_last_d;
    logic             ptr_q, ptr_d;
    logic             s_q, s_d;
    logic             free, gnt_a, gnt_b, sel, accept, beat_last;
`ifdef GTECH_MUX2_ARB_LOCK_EN
    logic             lock_q, lock_d;
    logic             own_q, own_d;
`endif

    always_comb begin
        free  = !z_valid_q || bus.Z_READY;
        gnt_a = 1'b0;
        gnt_b = 1'b0;
`ifdef GTECH_MUX2_ARB_LOCK_EN
        // While locked only the owner may be granted; an idle owner leaves S parked on it.
        if (lock_q) begin
            gnt_a = !own_q && bus.A_VALID;
            gnt_b = own_q && bus.B_VALID;
        end else
`endif
        if (bus.A_VALID && bus.B_VALID) begin
            gnt_a = !ptr_q;
            gnt_b = ptr_q;
        end else begin
            gnt_a = bus.A_VALID;
            gnt_b = bus.B_VALID;
        end

        sel       = gnt_b || (!gnt_a && s_q);
        accept    = CD && free && (gnt_a || gnt_b);
        beat_last = sel ? bus.B_LAST : bus.A_LAST;

        z_valid_d = z_valid_q;
        z_data_d  = z_data_q;
        z_last_d  = z_last_q;
        ptr_d     = ptr_q;
        s_d       = (gnt_a || gnt_b) ? sel : s_q;
`ifdef GTECH_MUX2_ARB_LOCK_EN
        lock_d    = lock_q;
        own_d     = own_q;
`endif
        if (accept) begin
            z_valid_d = 1'b1;
            z_data_d  = sel ? bus.B_DATA : bus.A_DATA;
            z_last_d  = beat_last;
            ptr_d     = !sel;
`ifdef GTECH_MUX2_ARB_LOCK_EN
            if (!beat_last) begin
                lock_d = 1'b1;
                own_d  = sel;
                ptr_d  = ptr_q;
            end else begin
                lock_d = 1'b0;
            end
`endif
        end else if (bus.Z_READY) begin
            z_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CP) begin
        if (!CD) begin
            z_valid_q <= 1'b0;
            z_data_q  <= '0;
            z_last_q  <= 1'b0;
            ptr_q     <= 1'b0;
            s_q       <= 1'b0;
`ifdef GTECH_MUX2_ARB_LOCK_EN
            lock_q    <= 1'b0;
            own_q     <= 1'b0;
`endif
        end else begin
            z_valid_q <= z_valid_d;
            z_data_q  <= z_data_d;
            z_last_q  <= z_last_d;
            ptr_q     <= ptr_d;
            s_q       <= s_d;
`ifdef GTECH_MUX2_ARB_LOCK_EN
            lock_q    <= lock_d;
            own_q     <= own_d;
`endif
        end
    end

    assign bus.A_READY = accept && gnt_a;
    assign bus.B_READY = accept && gnt_b;
    assign bus.S       = sel;
    assign bus.Z_VALID = z_valid_q;
    assign bus.Z_DATA  = z_data_q;
    assign bus.Z_LAST  = z_last_q;
endmodule

// File: tb/tb_gtech_mux2_arb.sv
// Scoreboard bench for gtech_mux2_arb: a reference arbiter predicts READY/S and
// queues expected Z beats, which are compared while the DUT holds them.
module tb_gtech_mux2_arb;
    logic CP = 1'b0;
    logic CD = 1'b0;
    int   total = 0;
    int   bad   = 0;

    gtech_mux2_arb_if #(.WIDTH(8)) bus ();
    gtech_mux2_arb #(.WIDTH(8)) dut (.CP(CP), .CD(CD), .bus(bus));

    always #5 CP = ~CP;

    // reference state
    logic       m_zv, m_ptr, m_s, m_lock, m_own;
    logic [8:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [7:0] ad, input logic al,
                         input logic bv, input logic [7:0] bd, input logic bl,
                         input logic zr);
        bus.A_VALID = av; bus.A_DATA = ad; bus.A_LAST = al;
        bus.B_VALID = bv; bus.B_DATA = bd; bus.B_LAST = bl;
        bus.Z_READY = zr;
    endtask

    // One clock: drive, check combinational outputs and held beat, advance model.
    task automatic cyc(input logic av, input logic [7:0] ad, input logic al,
                       input logic bv, input logic [7:0] bd, input logic bl,
                       input logic zr);
        logic want, pick, fr, acc, lst;
        drive(av, ad, al, bv, bd, bl, zr);
        #1;
        want = av || bv;
        pick = (av && bv) ? m_ptr : bv;
        if (m_lock) begin
            want = m_own ? bv : av;
            pick = m_own;
        end
        fr  = !m_zv || zr;
        acc = fr && want;
        chk("a_ready", bus.A_READY, acc && !pick);
        chk("b_ready", bus.B_READY, acc && pick);
        chk("sel", bus.S, want ? pick : m_s);
        chk("z_valid", bus.Z_VALID, m_zv);
        if (m_zv) begin
            chk("z_beat", {bus.Z_LAST, bus.Z_DATA}, sb_q[0]);
            if (zr) void'(sb_q.pop_front());
        end
        if (want) m_s = pick;
        if (acc) begin
            lst = pick ? bl : al;
            sb_q.push_back({lst, pick ? bd : ad});
            m_zv = 1'b1;
`ifdef GTECH_MUX2_ARB_LOCK_EN
            if (!lst) begin
                m_lock = 1'b1;
                m_own  = pick;
            end else begin
                m_lock = 1'b0;
                m_ptr  = !pick;
            end
`else
            m_ptr = !pick;
`endif
        end else if (zr) begin
            m_zv = 1'b0;
        end
        @(posedge CP);
        #1;
    endtask

    task automatic rst_cycles(input int n);
        CD = 1'b0;
        drive(1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
        for (int i = 0; i < n; i++) begin
            #1;
            chk("rst_a_ready", bus.A_READY, 1'b0);
            chk("rst_b_ready", bus.B_READY, 1'b0);
            @(posedge CP);
            #1;
            chk("rst_z_valid", bus.Z_VALID, 1'b0);
            chk("rst_z_data", bus.Z_DATA, 8'h00);
            chk("rst_z_last", bus.Z_LAST, 1'b0);
        end
        m_zv = 0; m_ptr = 0; m_s = 0; m_lock = 0; m_own = 0;
        sb_q.delete();
        CD = 1'b1;
    endtask

    initial begin
        m_zv = 0; m_ptr = 0; m_s = 0; m_lock = 0; m_own = 0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge CP);
        #1;
        rst_cycles(2);

        // simultaneous requests alternate starting with A
        for (int i = 0; i < 6; i++) cyc(1, 8'h11, 1, 1, 8'h22, 1, 1);
        cyc(0, 8'h00, 0, 0, 8'h00, 0, 1);

        // lone requester B streams every cycle
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 1, 8'h5A, 1, 1);
        cyc(0, 8'h00, 0, 0, 8'h00, 0, 1);
        cyc(0, 8'h00, 0, 0, 8'h00, 0, 1);

        // backpressure: A accepted, then 4 stalled cycles, then B goes next
        cyc(1, 8'h11, 1, 1, 8'h22, 1, 1);
        for (int i = 0; i < 4; i++) cyc(1, 8'h11, 1, 1, 8'h22, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 8'h11, 1, 1, 8'h22, 1, 1);
        cyc(0, 8'h00, 0, 0, 8'h00, 0, 1);

        // packet of three A beats with B contending (locks when the feature is built)
        cyc(1, 8'hA0, 0, 1, 8'hB0, 1, 1);
        cyc(1, 8'hA1, 0, 1, 8'hB0, 1, 1);
        cyc(1, 8'hA2, 1, 1, 8'hB0, 1, 1);
        cyc(0, 8'h00, 0, 1, 8'hB1, 1, 1);
        cyc(0, 8'h00, 0, 0, 8'h00, 0, 1);

        // randomized traffic with random backpressure and LAST
        for (int i = 0; i < 60; i++)
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0, 8'h00, 1, 1);

        // reset while the slot holds 0x33
        cyc(1, 8'h33, 1, 0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0, 8'h00, 0, 0);
        rst_cycles(1);
        cyc(1, 8'h44, 1, 1, 8'h55, 1, 1);
        cyc(1, 8'h44, 1, 1, 8'h55, 1, 1);
        cyc(0, 8'h00, 0, 0, 8'h00, 0, 1);
        cyc(0, 8'h00, 0, 0, 8'h00, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
